// File: rtl/alu_pkg.sv
// Shared ALU definitions: instruction field widths/positions, opcode and
// entry-FSM enums, and the instruction packing helper.
package alu_pkg;

    localparam int OPW   = 3;
    localparam int DW    = 6;
    localparam int WORDW = 15;

    localparam int B_LSB  = 0;
    localparam int A_LSB  = B_LSB + DW;
    localparam int OP_LSB = A_LSB + DW;

    typedef enum logic [OPW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_RSV6 = 3'd6,
        OP_RSV7 = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_WAIT = 2'd3
    } state_e;

    function automatic logic [WORDW-1:0] pack_instr(
        input op_e           op,
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [WORDW-1:0] w;
        w = '0;
        w[OP_LSB +: OPW] = op;
        w[A_LSB  +: DW]  = a;
        w[B_LSB  +: DW]  = b;
        return w;
    endfunction

endpackage

// File: rtl/instr_packer_if.sv
// Write side of the instruction FIFO: packed word, write strobe, full flag.
interface instr_packer_if;
    import alu_pkg::*;

    logic [WORDW-1:0] dataOut;
    logic             wen;
    logic             full;

    modport master (output dataOut, output wen, input full);
    modport slave  (input dataOut, input wen, output full);

endinterface

// File: rtl/instr_packer.sv
// Operand-entry front end: three button presses stage A, B and opcode, then
// one FIFO write honouring full. Opcode range check under INSTR_PACKER_OPCHECK_EN.
module instr_packer
    import alu_pkg::*;
#(
    parameter int unsigned OP_MAX = 5,
    parameter int          CNT_W  = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             button,
    input  logic             cancel,
    input  logic [DW-1:0]    sw,
    instr_packer_if.master   fifo,
    output logic [1:0]       stage,
    output logic             err,
    output logic [CNT_W-1:0] wr_count
);

`ifdef INSTR_PACKER_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [DW-1:0]    a_q, a_d;
    logic [DW-1:0]    b_q, b_d;
    op_e              op_q, op_d;
    logic [WORDW-1:0] data_q, data_d;
    logic             wen_q, wen_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    op_e  sw_op;
    logic op_bad;

    assign sw_op  = op_e'(sw[OPW-1:0]);
    assign op_bad = OPCHECK && (32'(sw[OPW-1:0]) > OP_MAX);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        err_d   = 1'b0;

        if (cancel) begin
            // Abort wins over button and over a pending write.
            state_d = S_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = OP_ADD;
        end else begin
            unique case (state_q)
                S_A: if (button) begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: if (button) begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: if (button) begin
                    if (op_bad) begin
                        err_d = 1'b1;
                    end else begin
                        op_d = sw_op;
                        if (!fifo.full) begin
                            wen_d   = 1'b1;
                            data_d  = pack_instr(sw_op, a_q, b_q);
                            state_d = S_A;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
                S_WAIT: if (!fifo.full) begin
                    wen_d   = 1'b1;
                    data_d  = pack_instr(op_q, a_q, b_q);
                    state_d = S_A;
                end
                default: state_d = S_A;
            endcase
        end

        cnt_d = wen_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: staging registers are reset too, so an interrupted entry never leaks into a later word.
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            data_q  <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo.dataOut = data_q;
    assign fifo.wen     = wen_q;
    assign stage        = state_q;
    assign err          = err_q;
    assign wr_count     = cnt_q;

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: scoreboard of expected FIFO words,
// directed checks on stage/wen/err/wr_count, cancel, full-wait, wrap and reset.
module tb_instr_packer;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       button = 1'b0;
    logic       cancel = 1'b0;
    logic [5:0] sw     = '0;
    logic [1:0] stage;
    logic       err;
    logic [7:0] wr_count;

    instr_packer_if fifo_if ();

    instr_packer #(.OP_MAX(5), .CNT_W(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .button   (button),
        .cancel   (cancel),
        .sw       (sw),
        .fifo     (fifo_if.master),
        .stage    (stage),
        .err      (err),
        .wr_count (wr_count)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    int          n_written = 0;
    logic [14:0] sb_q[$];
    logic        prev_wen = 1'b0;

    function automatic logic [14:0] model_word(input logic [2:0] op, input logic [5:0] a,
                                               input logic [5:0] b);
        return {op, a, b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: every write strobe must match the oldest expected word.
    always @(negedge clock) begin
        if (fifo_if.wen === 1'b1) begin
            check("wen_back2back", 32'(prev_wen), 32'd0);
            if (sb_q.size() == 0) check("wen_unexpected", 32'(fifo_if.wen), 32'd0);
            else                  check("data", 32'(fifo_if.dataOut), 32'(sb_q.pop_front()));
        end
        prev_wen <= fifo_if.wen;
    end

    task automatic press(input logic [5:0] v);
        @(negedge clock);
        button = 1'b1;
        sw     = v;
        @(negedge clock);
        button = 1'b0;
        sw     = 6'($urandom);
    endtask

    task automatic write_word(input logic [5:0] a, input logic [5:0] b, input logic [2:0] op,
                              input bit chk);
        fifo_if.full = 1'b0;
        press(a);
        if (chk) check("stage_b", 32'(stage), 32'd1);
        press(b);
        if (chk) check("stage_op", 32'(stage), 32'd2);
        sb_q.push_back(model_word(op, a, b));
        n_written++;
        press({3'($urandom), op});
        if (chk) begin
            check("wen_latency", 32'(fifo_if.wen), 32'd1);
            check("stage_back_a", 32'(stage), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        fifo_if.full = 1'b0;
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_data", 32'(fifo_if.dataOut), 32'd0);
        check("rst_wen", 32'(fifo_if.wen), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Basic entry, full low.
        write_word(6'h05, 6'h3E, 3'd1, 1'b1);
        @(negedge clock);
        check("wen_pulse_once", 32'(fifo_if.wen), 32'd0);
        check("count_one", 32'(wr_count), 32'd1);
        check("data_hold", 32'(fifo_if.dataOut), 32'(model_word(3'd1, 6'h05, 6'h3E)));

        // Full high: park in WAIT, ignore presses, write once when full drops.
        fifo_if.full = 1'b1;
        press(6'h2A);
        press(6'h15);
        press(6'h04);
        check("wait_stage", 32'(stage), 32'd3);
        check("wait_no_wen", 32'(fifo_if.wen), 32'd0);
        press(6'h3F);
        press(6'h00);
        check("wait_ignores_button", 32'(stage), 32'd3);
        sb_q.push_back(model_word(3'd4, 6'h2A, 6'h15));
        n_written++;
        @(negedge clock);
        fifo_if.full = 1'b0;
        @(negedge clock);
        fifo_if.full = 1'b1;
        check("wait_wen", 32'(fifo_if.wen), 32'd1);
        @(negedge clock);
        check("wait_wen_once", 32'(fifo_if.wen), 32'd0);
        check("wait_stage_a", 32'(stage), 32'd0);
        fifo_if.full = 1'b0;

        // Cancel together with the opcode press.
        press(6'h11);
        press(6'h22);
        @(negedge clock);
        button = 1'b1;
        cancel = 1'b1;
        sw     = 6'h03;
        @(negedge clock);
        button = 1'b0;
        cancel = 1'b0;
        check("cancel_stage", 32'(stage), 32'd0);
        check("cancel_no_wen", 32'(fifo_if.wen), 32'd0);
        write_word(6'h07, 6'h09, 3'd2, 1'b1);

        // Cancel while waiting on full.
        fifo_if.full = 1'b1;
        press(6'h01);
        press(6'h02);
        press(6'h03);
        check("cwait_stage", 32'(stage), 32'd3);
        @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        fifo_if.full = 1'b0;
        check("cwait_stage_a", 32'(stage), 32'd0);
        repeat (3) @(negedge clock);
        check("cwait_no_wen", 32'(fifo_if.wen), 32'd0);

        // Out-of-range opcode.
        press(6'h12);
        press(6'h2D);
`ifdef INSTR_PACKER_OPCHECK_EN
        press(6'h07);
        check("op_err", 32'(err), 32'd1);
        check("op_err_stage", 32'(stage), 32'd2);
        check("op_err_no_wen", 32'(fifo_if.wen), 32'd0);
        @(negedge clock);
        check("op_err_pulse", 32'(err), 32'd0);
        sb_q.push_back(model_word(3'd3, 6'h12, 6'h2D));
        n_written++;
        press(6'h03);
        check("op_retry_wen", 32'(fifo_if.wen), 32'd1);
`else
        sb_q.push_back(model_word(3'd7, 6'h12, 6'h2D));
        n_written++;
        press(6'h07);
        check("op7_wen", 32'(fifo_if.wen), 32'd1);
        check("op7_no_err", 32'(err), 32'd0);
`endif

        // Wrap the write counter.
        while ((n_written % 256) != 0)
            write_word(6'($urandom), 6'($urandom), 3'($urandom_range(0, 5)), 1'b0);
        @(negedge clock);
        check("count_wrap", 32'(wr_count), 32'd0);
        write_word(6'h15, 6'h2A, 3'd5, 1'b0);
        @(negedge clock);
        check("count_after_wrap", 32'(wr_count), 32'(8'(n_written)));

        // Asynchronous reset while waiting on full.
        fifo_if.full = 1'b1;
        press(6'h0A);
        press(6'h0B);
        press(6'h02);
        check("rwait_stage", 32'(stage), 32'd3);
        #2 reset = 1'b0;
        #1;
        check("arst_stage", 32'(stage), 32'd0);
        check("arst_data", 32'(fifo_if.dataOut), 32'd0);
        check("arst_count", 32'(wr_count), 32'd0);
        check("arst_wen", 32'(fifo_if.wen), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        n_written = 0;
        @(negedge clock);
        reset = 1'b1;
        fifo_if.full = 1'b0;
        repeat (4) @(negedge clock);
        check("arst_no_write", 32'(wr_count), 32'd0);
        check("arst_stage_idle", 32'(stage), 32'd0);

        repeat (2) @(negedge clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
